// File: rtl/mux_sel_scheduler.sv
// Round-robin select generator for a 4:1 mux.
// Holds each granted source on sel for a bounded dwell.
module mux_sel_scheduler #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W = $clog2(HOLD_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       busy
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lptr_q, lptr_d;

  logic       pick_vld;
  logic [1:0] pick_idx;
  logic [1:0] cand;
  logic       release_w;

  // Round-robin search starting after the last grant; last grant checked last
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = lptr_q;
    cand     = lptr_q;
    for (int k = 4; k >= 1; k--) begin
      cand = lptr_q + 2'(k);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign release_w = !req[sel_q] || (cnt_q == CNT_W'(HOLD_CYCLES));

  // Next-state: grant, extend dwell, hand off, or fall back to idle
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    lptr_d  = lptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d = S_GRANT;
          sel_d   = pick_idx;
          gnt_d   = 4'b0001 << pick_idx;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(1);
          lptr_d  = pick_idx;
        end
      end
      S_GRANT: begin
        if (!release_w) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (pick_vld) begin
          sel_d  = pick_idx;
          gnt_d  = 4'b0001 << pick_idx;
          busy_d = 1'b1;
          cnt_d  = CNT_W'(1);
          lptr_d = pick_idx;
        end else begin
          state_d = S_IDLE;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= 2'b00;
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      lptr_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      lptr_q  <= lptr_d;
    end
  end

  assign sel  = sel_q;
  assign gnt  = gnt_q;
  assign busy = busy_q;

endmodule
